// File: rtl/pirisc_core.sv
// pirisc_core: multicycle RV32I-subset core with instruction ROM, data RAM, register file and ALU.
// One instruction at a time: FETCH, DECODE, EXEC, (MEM), WB; ECALL parks the core until reset.
module pirisc_core #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "imem.hex"
) (
  input  logic clk,
  input  logic reset,
  output logic viewAlu,
  input  logic go_contr
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  state_e state_q, state_d;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf_q [32];
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q, npc_q;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_lui, is_jal, is_br, is_lw, is_sw, is_opi, is_op, is_ecall, valid, rf_we;
  assign is_lui   = (opcode == 7'b0110111);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_br    = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
  // Immediate shifts and SLTIU are outside the subset and fall through as NOPs.
  assign is_opi   = (opcode == 7'b0010011) && (funct3 != 3'b001) && (funct3 != 3'b011)
                    && (funct3 != 3'b101);
  assign is_op    = (opcode == 7'b0110011)
                    && (((funct7 == 7'b0000000) && (funct3 != 3'b011))
                        || ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign is_ecall = (ir_q == 32'h0000_0073);
  assign valid    = is_lui | is_jal | is_br | is_lw | is_sw | is_opi | is_op;
  assign rf_we    = (is_lui | is_jal | is_opi | is_op | is_lw) && (rd != 5'd0);

  logic [31:0] imm_d, op2, alu_res, sum, target;
  logic        taken;

  always_comb begin
    imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
    if (is_sw)       imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_br)  imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else if (is_jal) imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    else if (is_lui) imm_d = {ir_q[31:12], 12'h000};
  end

  always_comb begin
    op2     = (is_op || is_br) ? b_q : imm_q;
    alu_res = '0;
    if (is_lui)             alu_res = imm_q;
    else if (is_jal)        alu_res = pc_q + 32'd4;
    else if (is_br)         alu_res = a_q - b_q;
    else if (is_lw | is_sw) alu_res = a_q + imm_q;
    else begin
      case (funct3)
        3'b000:  alu_res = (is_op && funct7[5]) ? a_q - op2 : a_q + op2;
        3'b001:  alu_res = a_q << op2[4:0];
        3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op2)};
        3'b100:  alu_res = a_q ^ op2;
        3'b101:  alu_res = a_q >> op2[4:0];
        3'b110:  alu_res = a_q | op2;
        3'b111:  alu_res = a_q & op2;
        default: alu_res = '0;
      endcase
    end
    sum    = pc_q + imm_q;
    target = {sum[31:2], 2'b00};
    taken  = is_jal || (is_br && (funct3[0] ? (alu_res != 32'd0) : (alu_res == 32'd0)));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (go_contr) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = is_ecall ? StHalt : StExec;
      StExec:   state_d = (is_lw || is_sw) ? StMem : StWb;
      StMem:    state_d = StWb;
      StWb:     state_d = go_contr ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      viewAlu <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      npc_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StFetch: ir_q <= imem[pc_q[2 +: IAW]];
        StDecode: begin
          a_q   <= rf_q[rs1];
          b_q   <= rf_q[rs2];
          imm_q <= imm_d;
        end
        StExec: begin
          alu_q <= alu_res;
          npc_q <= taken ? target : pc_q + 32'd4;
          if (valid) viewAlu <= alu_res[0];
        end
        StMem: if (is_lw) mdr_q <= dmem[alu_q[2 +: DAW]];
        StWb: begin
          if (rf_we) rf_q[rd] <= is_lw ? mdr_q : alu_q;
          pc_q <= npc_q;
        end
        default: ;
      endcase
    end
  end

  // Gated on state_q, which reset forces to idle, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (state_q == StMem && is_sw) dmem[alu_q[2 +: DAW]] <= b_q;
  end

endmodule

// File: tb/tb_pirisc_core.sv
// Bench for pirisc_core: directed programs plus a random program, each instruction checked
// against an instruction-level model of the subset.
module tb_pirisc_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go_contr = 1'b0;
  logic viewAlu;

  always #5 clk = ~clk;

  pirisc_core #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256),
    .IMEM_INIT ("")
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .viewAlu (viewAlu),
    .go_contr(go_contr)
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {
    MnLui, MnJal, MnBeq, MnBne, MnLw, MnSw, MnAddi, MnSlti, MnXori, MnOri, MnAndi,
    MnAdd, MnSub, MnSll, MnSrl, MnSlt, MnXor, MnOr, MnAnd, MnNop, MnEcall
  } mn_e;

  mn_e         p_mn  [256];
  logic [4:0]  p_rd  [256];
  logic [4:0]  p_rs1 [256];
  logic [4:0]  p_rs2 [256];
  logic [31:0] p_imm [256];

  logic [31:0] m_rf   [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc;
  logic        m_va;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input mn_e mn, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    case (mn)
      MnLui:   return {imm[31:12], rd, 7'b0110111};
      MnJal:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      MnBeq:   return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      MnBne:   return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      MnLw:    return {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      MnSw:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      MnAddi:  return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      MnSlti:  return {imm[11:0], rs1, 3'b010, rd, 7'b0010011};
      MnXori:  return {imm[11:0], rs1, 3'b100, rd, 7'b0010011};
      MnOri:   return {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
      MnAndi:  return {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
      MnAdd:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      MnSub:   return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      MnSll:   return {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
      MnSrl:   return {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
      MnSlt:   return {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
      MnXor:   return {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      MnOr:    return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      MnAnd:   return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      MnEcall: return 32'h0000_0073;
      default: return {imm[24:0], 7'b0001111};  // FENCE opcode: not in the subset
    endcase
  endfunction

  task automatic put(input logic [7:0] idx, input mn_e mn, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    p_mn[idx] = mn; p_rd[idx] = rd; p_rs1[idx] = rs1; p_rs2[idx] = rs2; p_imm[idx] = imm;
    dut.imem[idx] = enc(mn, rd, rs1, rs2, imm);
  endtask

  task automatic rand_put(input logic [7:0] idx);
    mn_e         mn = mn_e'($urandom_range(0, 19));
    logic [31:0] r  = $urandom;
    logic [31:0] imm;
    case (mn)
      MnLui:        imm = {r[31:12], 12'h000};
      MnJal:        imm = {{11{r[20]}}, r[20:1], 1'b0};
      MnBeq, MnBne: imm = {{19{r[12]}}, r[12:1], 1'b0};
      MnNop:        imm = r;
      default:      imm = {{20{r[11]}}, r[11:0]};
    endcase
    put(idx, mn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
        imm);
  endtask

  // Executes one instruction of the program at m_pc on the model state.
  task automatic model_step(output int lat, output logic [4:0] rd, output bit wr, output bit sw,
                            output logic [7:0] sw_idx);
    logic [7:0]  i   = m_pc[9:2];
    logic [31:0] a   = m_rf[p_rs1[i]];
    logic [31:0] b   = m_rf[p_rs2[i]];
    logic [31:0] imm = p_imm[i];
    logic [31:0] tgt = (m_pc + imm) & 32'hFFFF_FFFC;
    logic [31:0] nxt = m_pc + 32'd4;
    logic [31:0] res = 32'd0;
    logic [31:0] val;
    bit          upd = 1'b1;
    lat = 4; rd = p_rd[i]; wr = 1'b1; sw = 1'b0; sw_idx = 8'd0;
    case (p_mn[i])
      MnLui:  res = imm;
      MnJal:  begin res = m_pc + 32'd4; nxt = tgt; end
      MnBeq:  begin res = a - b; wr = 1'b0; if (a == b) nxt = tgt; end
      MnBne:  begin res = a - b; wr = 1'b0; if (a != b) nxt = tgt; end
      MnLw:   begin res = a + imm; lat = 5; end
      MnSw:   begin res = a + imm; lat = 5; wr = 1'b0; sw = 1'b1; end
      MnAddi: res = a + imm;
      MnSlti: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      MnXori: res = a ^ imm;
      MnOri:  res = a | imm;
      MnAndi: res = a & imm;
      MnAdd:  res = a + b;
      MnSub:  res = a - b;
      MnSll:  res = a << b[4:0];
      MnSrl:  res = a >> b[4:0];
      MnSlt:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      MnXor:  res = a ^ b;
      MnOr:   res = a | b;
      MnAnd:  res = a & b;
      default: begin upd = 1'b0; wr = 1'b0; end
    endcase
    val = res;
    if (p_mn[i] == MnLw) val = m_dmem[res[9:2]];
    if (sw) begin
      sw_idx = res[9:2];
      m_dmem[sw_idx] = b;
    end
    if (upd) m_va = res[0];
    if (wr && rd != 5'd0) m_rf[rd] = val;
    m_pc = nxt;
  endtask

  task automatic step_check(input string tag);
    int         lat;
    logic [4:0] rd;
    bit         wr, sw;
    logic [7:0] sw_idx;
    model_step(lat, rd, wr, sw, sw_idx);
    repeat (lat) @(posedge clk);
    #1;
    chk({tag, " pc"}, dut.pc_q, m_pc);
    chk({tag, " viewAlu"}, {31'b0, viewAlu}, {31'b0, m_va});
    if (wr) chk({tag, " rd"}, dut.rf_q[rd], m_rf[rd]);
    if (sw) chk({tag, " dmem"}, dut.dmem[sw_idx], m_dmem[sw_idx]);
  endtask

  task automatic do_reset();
    go_contr = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
    m_pc = 32'd0;
    m_va = 1'b0;
  endtask

  // From idle: raise go_contr, then one edge moves the core into FETCH.
  task automatic start();
    @(negedge clk);
    go_contr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat;
    logic [4:0] rdx;
    bit         wrx, swx;
    logic [7:0] swi;

    for (int i = 0; i < 256; i++) begin
      put(8'(i), MnNop, 5'd0, 5'd0, 5'd0, 32'd0);
      m_dmem[i] = 32'd0;
    end
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
    m_pc = 32'd0;
    m_va = 1'b0;

    // Reset held with go low.
    repeat (10) @(posedge clk);
    #1;
    chk("reset pc", dut.pc_q, 32'd0);
    chk("reset viewAlu", {31'b0, viewAlu}, 32'd0);
    chk("reset ir", dut.ir_q, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle pc", dut.pc_q, 32'd0);

    // Single ADDI: EXEC result after 3 clocks in flight, writeback after 4.
    put(8'd0, MnAddi, 5'd1, 5'd0, 5'd0, 32'd1);
    start();
    repeat (3) @(posedge clk);
    #1;
    chk("addi exec viewAlu", {31'b0, viewAlu}, 32'd1);
    chk("addi x1 before wb", dut.rf_q[1], 32'd0);
    @(posedge clk);
    #1;
    chk("addi x1", dut.rf_q[1], 32'd1);
    chk("addi pc", dut.pc_q, 32'd4);

    // Arithmetic and memory round trip.
    do_reset();
    put(8'd0, MnAddi, 5'd1, 5'd0, 5'd0, 32'd5);
    put(8'd1, MnAddi, 5'd2, 5'd0, 5'd0, 32'd3);
    put(8'd2, MnSub,  5'd3, 5'd1, 5'd2, 32'd0);
    put(8'd3, MnSw,   5'd0, 5'd0, 5'd3, 32'd0);
    put(8'd4, MnLw,   5'd4, 5'd0, 5'd0, 32'd0);
    start();
    step_check("mem addi5");
    step_check("mem addi3");
    step_check("mem sub");
    chk("sub x3", dut.rf_q[3], 32'd2);
    chk("sub viewAlu", {31'b0, viewAlu}, 32'd0);
    step_check("mem sw");
    chk("sw dmem0", dut.dmem[0], 32'd2);
    step_check("mem lw");
    chk("lw x4", dut.rf_q[4], 32'd2);

    // Taken BNE skips one instruction.
    do_reset();
    put(8'd0, MnAddi, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    put(8'd1, MnBne,  5'd0, 5'd1, 5'd0, 32'd8);
    put(8'd2, MnAddi, 5'd5, 5'd0, 5'd0, 32'd7);
    put(8'd3, MnAddi, 5'd6, 5'd0, 5'd0, 32'd6);
    start();
    step_check("br addi");
    step_check("br bne");
    chk("bne pc", dut.pc_q, 32'd12);
    step_check("br target");
    chk("bne x5 skipped", dut.rf_q[5], 32'd0);

    // x0 stays zero; ECALL halts until reset.
    do_reset();
    put(8'd0, MnAddi, 5'd0, 5'd0, 5'd0, 32'd9);
    put(8'd1, MnEcall, 5'd0, 5'd0, 5'd0, 32'd0);
    start();
    step_check("x0 addi");
    chk("x0 zero", dut.rf_q[0], 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("halt pc frozen", dut.pc_q, 32'd4);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("post-halt reset pc", dut.pc_q, 32'd0);
    start();
    step_check("post-halt rerun");

    // go_contr dropped mid-instruction: finish it, idle, then resume.
    do_reset();
    put(8'd0, MnAddi, 5'd1, 5'd0, 5'd0, 32'd1);
    put(8'd1, MnAddi, 5'd2, 5'd0, 5'd0, 32'd2);
    put(8'd2, MnAddi, 5'd3, 5'd0, 5'd0, 32'd3);
    start();
    step_check("go first");
    model_step(lat, rdx, wrx, swx, swi);
    repeat (2) @(posedge clk);
    @(negedge clk);
    go_contr = 1'b0;
    repeat (lat - 2) @(posedge clk);
    #1;
    chk("go drop pc", dut.pc_q, 32'd8);
    chk("go drop x2", dut.rf_q[2], 32'd2);
    repeat (10) @(posedge clk);
    #1;
    chk("go idle pc", dut.pc_q, 32'd8);
    chk("go idle x3", dut.rf_q[3], 32'd0);
    start();
    step_check("go resume");

    // Reset while a store sits in MEM: no write may land.
    do_reset();
    put(8'd0, MnAddi, 5'd7, 5'd0, 5'd0, 32'd5);
    put(8'd1, MnSw,   5'd0, 5'd0, 5'd7, 32'd64);
    start();
    step_check("abort addi");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort dmem", dut.dmem[16], m_dmem[16]);
    chk("abort x7", dut.rf_q[7], 32'd0);
    chk("abort pc", dut.pc_q, 32'd0);

    // Random program across the whole instruction ROM.
    do_reset();
    for (int i = 0; i < 256; i++) rand_put(8'(i));
    start();
    for (int n = 0; n < 300; n++) step_check($sformatf("rand %0d", n));
    for (int r = 0; r < 32; r++) chk($sformatf("rand final x%0d", r), dut.rf_q[r], m_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
